// File: rtl/fsm_remainder_pkg.sv
// rtl/fsm_remainder_pkg.sv - shared types, constants and width helper for the serial remainder FSM
// Contents:
//   mode_e        : bit-order mode encoding (MODE_MSB_FIRST=0, MODE_LSB_FIRST=1)
//   BIT_COUNT_MAX : saturation value of the optional accepted-bit counter
//   rem_width()   : remainder width, max(1, clog2(divisor))
package fsm_remainder_pkg;

  typedef enum logic {
    MODE_MSB_FIRST = 1'b0,
    MODE_LSB_FIRST = 1'b1
  } mode_e;

  localparam logic [15:0] BIT_COUNT_MAX = 16'hFFFF;

  function automatic int rem_width(input int divisor);
    int w;
    w = $clog2(divisor);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/mod_add_reduce.sv
// rtl/mod_add_reduce.sv - combinational (a + b + cin) mod DIVISOR with a single conditional subtract
// Parameters:
//   DIVISOR : modulus
//   W       : operand width
// Ports:
//   a_i   [W-1:0] : first operand, expected < DIVISOR
//   b_i   [W-1:0] : second operand, expected < DIVISOR
//   cin_i         : extra unit added to the sum
//   sum_o [W-1:0] : reduced result, always < DIVISOR
module mod_add_reduce #(
  parameter int DIVISOR = 3,
  parameter int W       = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o
);

  localparam logic [W:0] MOD = (W+1)'(DIVISOR);

  // With both operands below DIVISOR the raw sum is at most 2*DIVISOR-1,
  // so one subtract always lands back in range.
  logic [W:0] raw;

  assign raw = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

  always_comb begin
    sum_o = raw[W-1:0];
    if (raw >= MOD) sum_o = W'(raw - MOD);
  end

endmodule

// File: rtl/fsm_remainder_param.sv
// rtl/fsm_remainder_param.sv - running remainder of a serial bit stream modulo DIVISOR
// Optional feature macro: FSM_REMAINDER_BIT_COUNT_EN adds the bit_count output.
// Parameters:
//   DIVISOR            : modulus, 2..255
//   FROM_RIGHT_DEFAULT : bit order after reset (1 = LSB first, 0 = MSB first)
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous stream restart, wins over valid
//   from_right : bit order, sampled only while clear=1
//   valid      : qualifies new_bit
//   new_bit    : next stream bit
//   rem        : registered remainder of the accepted stream
//   bit_count  : accepted bits, saturating (only with FSM_REMAINDER_BIT_COUNT_EN)
//   divisible  : rem == 0
module fsm_remainder_param
  import fsm_remainder_pkg::*;
#(
  parameter int  DIVISOR            = 3,
  parameter bit  FROM_RIGHT_DEFAULT = 1'b1,
  localparam int W                  = rem_width(DIVISOR)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         from_right,
  input  logic         valid,
  input  logic         new_bit,
  output logic [W-1:0] rem,
`ifdef FSM_REMAINDER_BIT_COUNT_EN
  output logic [15:0]  bit_count,
`endif
  output logic         divisible
);

  localparam logic [W:0]   DIV_EXT = (W+1)'(DIVISOR);
  localparam logic [W-1:0] ONE     = W'(1);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] weight_q, weight_d;
  mode_e        mode_q, mode_d;

  logic [W-1:0] rem_op, weight_op;
  logic [W-1:0] addend;
  logic         carry_in;
  logic [W-1:0] rem_sum, weight_sum;

  // Codes at or above DIVISOR cannot be reached; treating them as 0 means
  // the next accepted bit pulls the state back into range.
  assign rem_op    = ({1'b0, rem_q}    < DIV_EXT) ? rem_q    : '0;
  assign weight_op = ({1'b0, weight_q} < DIV_EXT) ? weight_q : '0;

  // MSB first: rem + rem + bit = 2*rem + bit.
  // LSB first: rem + (bit ? weight : 0).
  always_comb begin
    addend   = '0;
    carry_in = 1'b0;
    if (mode_q == MODE_MSB_FIRST) begin
      addend   = rem_op;
      carry_in = new_bit;
    end else if (new_bit) begin
      addend = weight_op;
    end
  end

  mod_add_reduce #(.DIVISOR(DIVISOR), .W(W)) u_rem_reduce (
    .a_i   (rem_op),
    .b_i   (addend),
    .cin_i (carry_in),
    .sum_o (rem_sum)
  );

  // weight doubles modulo DIVISOR, walking the cycle of 2^k mod DIVISOR
  mod_add_reduce #(.DIVISOR(DIVISOR), .W(W)) u_weight_reduce (
    .a_i   (weight_op),
    .b_i   (weight_op),
    .cin_i (1'b0),
    .sum_o (weight_sum)
  );

  always_comb begin
    rem_d    = rem_q;
    weight_d = weight_q;
    mode_d   = mode_q;
    if (clear) begin
      rem_d    = '0;
      weight_d = ONE;
      mode_d   = mode_e'(from_right);
    end else if (valid) begin
      rem_d = rem_sum;
      if (mode_q == MODE_LSB_FIRST) weight_d = weight_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      weight_q <= ONE;
      mode_q   <= mode_e'(FROM_RIGHT_DEFAULT);
    end else begin
      rem_q    <= rem_d;
      weight_q <= weight_d;
      mode_q   <= mode_d;
    end
  end

  assign rem       = rem_q;
  assign divisible = (rem_q == '0);

`ifdef FSM_REMAINDER_BIT_COUNT_EN
  logic [15:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (clear) begin
      bit_count_d = '0;
    end else if (valid && (bit_count_q != BIT_COUNT_MAX)) begin
      bit_count_d = bit_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bit_count_q <= '0;
    else     bit_count_q <= bit_count_d;
  end

  assign bit_count = bit_count_q;
`else
  // no accepted-bit counter in this build
`endif

endmodule

// File: tb/tb_fsm_remainder_param.sv
// tb/tb_fsm_remainder_param.sv - self-checking bench for fsm_remainder_param with DIVISOR 3, 5 and 7
module tb_fsm_remainder_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic from_right = 1'b0;
  logic valid = 1'b0;
  logic new_bit = 1'b0;

  logic [1:0] rem3;
  logic [2:0] rem5, rem7;
  logic       div3, div5, div7;
`ifdef FSM_REMAINDER_BIT_COUNT_EN
  logic [15:0] bc3, bc5, bc7;
`endif

  always #5 clk = ~clk;

  fsm_remainder_param #(.DIVISOR(3), .FROM_RIGHT_DEFAULT(1'b1)) dut3 (
    .clk(clk), .rst(rst), .clear(clear), .from_right(from_right),
    .valid(valid), .new_bit(new_bit), .rem(rem3),
`ifdef FSM_REMAINDER_BIT_COUNT_EN
    .bit_count(bc3),
`endif
    .divisible(div3)
  );

  fsm_remainder_param #(.DIVISOR(5), .FROM_RIGHT_DEFAULT(1'b1)) dut5 (
    .clk(clk), .rst(rst), .clear(clear), .from_right(from_right),
    .valid(valid), .new_bit(new_bit), .rem(rem5),
`ifdef FSM_REMAINDER_BIT_COUNT_EN
    .bit_count(bc5),
`endif
    .divisible(div5)
  );

  fsm_remainder_param #(.DIVISOR(7), .FROM_RIGHT_DEFAULT(1'b1)) dut7 (
    .clk(clk), .rst(rst), .clear(clear), .from_right(from_right),
    .valid(valid), .new_bit(new_bit), .rem(rem7),
`ifdef FSM_REMAINDER_BIT_COUNT_EN
    .bit_count(bc7),
`endif
    .divisible(div7)
  );

  int checks = 0;
  int failures = 0;

  // reference: the accepted bits since the last restart, the bit order, and a count
  bit q[$];
  bit m_lsb = 1'b1;
  int m_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // value of the stream as a plain integer, then reduced
  function automatic int model_rem(input int d);
    longint v;
    v = 0;
    foreach (q[k]) begin
      if (m_lsb) v = v + (longint'(q[k]) << k);
      else       v = (v << 1) + longint'(q[k]);
    end
    return int'(v % longint'(d));
  endfunction

  task automatic check_all(input string tag);
    int e3, e5, e7;
    e3 = model_rem(3);
    e5 = model_rem(5);
    e7 = model_rem(7);
    check_eq({tag, "/rem3"}, 32'(rem3), 32'(e3));
    check_eq({tag, "/rem5"}, 32'(rem5), 32'(e5));
    check_eq({tag, "/rem7"}, 32'(rem7), 32'(e7));
    check_eq({tag, "/div3"}, 32'(div3), 32'(e3 == 0));
    check_eq({tag, "/div5"}, 32'(div5), 32'(e5 == 0));
    check_eq({tag, "/div7"}, 32'(div7), 32'(e7 == 0));
`ifdef FSM_REMAINDER_BIT_COUNT_EN
    check_eq({tag, "/bc3"}, 32'(bc3), 32'(m_count));
    check_eq({tag, "/bc7"}, 32'(bc7), 32'(m_count));
`endif
  endtask

  // drive one cycle, advance the reference on the edge, check 1 time unit later
  task automatic step(input bit v, input bit b, input bit c, input bit fr, input string tag);
    valid = v;
    new_bit = b;
    clear = c;
    from_right = fr;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_lsb = fr;
      m_count = 0;
    end else if (v) begin
      q.push_back(b);
      if (m_count < 65535) m_count++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int exp029[4] = '{1, 0, 0, 2};
    int exp030[4] = '{1, 2, 0, 1};
    int exp031[4] = '{1, 3, 0, 1};
    int exp032[4] = '{1, 1, 1, 0};
    bit bits029[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit bits030[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit val032[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // first bit lands on the first edge after reset release, LSB first by default
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits029[i], 1'b0, 1'b0, "d3_lsb");
      check_eq("d3_lsb_const", 32'(rem3), 32'(exp029[i]));
      check_eq("d3_lsb_div", 32'(div3), 32'(exp029[i] == 0));
    end

    step(1'b0, 1'b0, 1'b1, 1'b0, "clr_msb");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits030[i], 1'b0, 1'b1, "d5_msb");
      check_eq("d5_msb_const", 32'(rem5), 32'(exp030[i]));
    end

    step(1'b0, 1'b0, 1'b1, 1'b1, "clr_lsb");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, "d7_wrap");
      check_eq("d7_wrap_const", 32'(rem7), 32'(exp031[i]));
    end

    step(1'b0, 1'b0, 1'b1, 1'b1, "clr_lsb2");
    for (int i = 0; i < 4; i++) begin
      step(val032[i], val032[i] ? 1'b1 : 1'($urandom), 1'b0, 1'b0, "valid_gap");
      check_eq("valid_gap_const", 32'(rem3), 32'(exp032[i]));
    end

    // clear and valid together: the bit is dropped
    step(1'b1, 1'b1, 1'b0, 1'b0, "pre_clr");
    step(1'b1, 1'b1, 1'b1, 1'b1, "clr_vs_valid");
    check_eq("clr_vs_valid_rem7", 32'(rem7), 32'd0);

    // asynchronous reset between edges, mid MSB-first stream
    step(1'b0, 1'b0, 1'b1, 1'b0, "clr_msb2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1, "pre_rst");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    q.delete();
    m_lsb = 1'b1;
    m_count = 0;
    check_all("async_rst");
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
    step(1'b1, 1'b0, 1'b0, 1'b0, "post_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
    check_eq("post_rst_const", 32'(rem3), 32'd2);

    // random streams with random order, gaps and restarts
    for (int i = 0; i < 400; i++) begin
      bit c;
      c = (q.size() >= 40) || ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom), c, 1'($urandom), "rand");
    end

`ifdef FSM_REMAINDER_BIT_COUNT_EN
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr_sat");
    for (int i = 0; i < 65540; i++) begin
      valid = 1'b1;
      new_bit = 1'($urandom);
      clear = 1'b0;
      @(posedge clk);
      #1;
    end
    check_eq("sat_bc3", 32'(bc3), 32'd65535);
    check_eq("sat_bc5", 32'(bc5), 32'd65535);
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr_after_sat");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
